// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage.
//   Owns the PC and drives a combinational-read, word-indexed instruction
//   memory. Fetched words are buffered, each with its PC+4, in a small
//   circular queue. Decode drains the queue over a valid/ready handshake.
//   A taken branch redirects the PC and flushes the queue.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   imem_addr/read/data word index (pc>>2), read enable, same-cycle read data
//   branch_taken/addr   redirect request and target byte address
//   out_valid/ready     handshake toward decode
//   out_instr/out_pc    head instruction and its PC+4 (zero when !out_valid)
module fetch_stage #(
  parameter int                INSTR_W     = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_read,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instr_buf_q [QUEUE_DEPTH];
  logic [ADDR_W-1:0]  pc_buf_q    [QUEUE_DEPTH];

  logic              fetch_en;
  logic              pop;
  logic [ADDR_W-1:0] pc_plus4;
  logic              unused_addr_lsb;

  // Word alignment bits of the branch target are dropped.
  assign unused_addr_lsb = ^branch_addr[1:0];

  // Fetch depends only on occupancy, never on out_ready, so a full queue
  // stalls for one cycle even when decode is draining it.
  assign fetch_en  = !reset && !branch_taken && (count_q < CNT_W'(QUEUE_DEPTH));
  assign pop       = out_valid && out_ready;
  assign pc_plus4  = pc_q + ADDR_W'(4);

  assign imem_addr = pc_q >> 2;
  assign imem_read = fetch_en;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_buf_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_buf_q[rd_ptr_q]    : '0;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (branch_taken) begin
      // Redirect wins over everything; a coincident pop is simply dropped
      // along with the rest of the queue.
      pc_d     = {branch_addr[ADDR_W-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch_en) begin
        pc_d     = pc_plus4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({fetch_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (fetch_en) begin
      instr_buf_q[wr_ptr_q] <= imem_data;
      pc_buf_q[wr_ptr_q]    <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr, imem_data, branch_addr;
  logic        imem_read, branch_taken, out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  logic [7:0]  d8_imem_addr, d8_out_pc;
  logic        d8_imem_read, d8_out_valid;
  logic [31:0] d8_imem_data, d8_out_instr;
  logic        d8_ready = 1'b1;
  logic        d8_branch = 1'b0;
  logic [7:0]  d8_baddr = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hE000_0000 + a;
  endfunction

  assign imem_data    = mem(imem_addr);
  assign d8_imem_data = mem({24'b0, d8_imem_addr});

  fetch_stage #(.INSTR_W(32), .ADDR_W(32), .RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_data(imem_data), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_stage #(.INSTR_W(32), .ADDR_W(8), .RESET_PC(8'hFC), .QUEUE_DEPTH(2)) dut8 (
    .clk(clk), .reset(reset), .imem_addr(d8_imem_addr), .imem_read(d8_imem_read),
    .imem_data(d8_imem_data), .branch_taken(d8_branch), .branch_addr(d8_baddr),
    .out_valid(d8_out_valid), .out_ready(d8_ready), .out_instr(d8_out_instr), .out_pc(d8_out_pc)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  // Reference model: the fetch queue as a plain queue of {word, pc+4} plus
  // a PC. Each cycle: branch flushes and redirects; otherwise the head may be
  // consumed, and if the queue was not full the word at pc is appended.
  ent_t        mq[$];
  logic [31:0] mpc = 32'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mpc <= 32'h0;
    end else if (branch_taken) begin
      mq.delete();
      mpc <= {branch_addr[31:2], 2'b00};
    end else if (mq.size() < DEPTH) begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      mq.push_back(ent_t'{instr: mem(mpc >> 2), pc: mpc + 32'd4});
      mpc <= mpc + 32'd4;
    end else if (out_ready) begin
      void'(mq.pop_front());
    end
  end

  // Monitor: compares what the DUT presents against the model's head.
  always @(negedge clk) begin
    ent_t h;
    #2;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("out_valid", {63'b0, out_valid}, {63'b0, mq.size() != 0});
    chk("out_instr", {32'b0, out_instr}, {32'b0, h.instr});
    chk("out_pc",    {32'b0, out_pc},    {32'b0, h.pc});
    chk("imem_read", {63'b0, imem_read},
        {63'b0, !reset && !branch_taken && (mq.size() < DEPTH)});
    chk("imem_addr", {32'b0, imem_addr}, {32'b0, mpc >> 2});
  end

  task automatic cyc(input logic r, input logic b, input logic [31:0] a);
    @(negedge clk);
    out_ready    = r;
    branch_taken = b;
    branch_addr  = a;
  endtask

  initial begin
    out_ready = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    // Streaming from reset, plus the narrow-PC wrap instance.
    reset = 1'b0; out_ready = 1'b1;
    #3;
    chk("d8_imem_addr0", {56'b0, d8_imem_addr}, 64'h3F);
    chk("d8_imem_read0", {63'b0, d8_imem_read}, 64'h1);
    @(negedge clk); #3;
    chk("d8_out_valid", {63'b0, d8_out_valid}, 64'h1);
    chk("d8_out_instr", {32'b0, d8_out_instr}, 64'hE000_003F);
    chk("d8_out_pc",    {56'b0, d8_out_pc},    64'h00);
    chk("d8_imem_addr1", {56'b0, d8_imem_addr}, 64'h00);
    chk("d8_no_x", {63'b0, $isunknown({d8_imem_addr, d8_imem_read, d8_out_valid,
                                      d8_out_instr, d8_out_pc})}, 64'h0);
    repeat (8) cyc(1, 0, 0);

    // Stall from reset, then drain.
    cyc(0, 0, 0); reset = 1'b1;
    cyc(0, 0, 0); reset = 1'b0;
    repeat (5) cyc(0, 0, 0);
    repeat (6) cyc(1, 0, 0);

    // Branches: from full, unaligned target, coincident pop, back-to-back.
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 32'h18);
    repeat (4) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 32'h1B);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 32'h40);
    cyc(1, 1, 32'h80);
    repeat (4) cyc(1, 0, 0);

    // Asynchronous reset mid-cycle with a full queue.
    repeat (3) cyc(0, 0, 0);
    @(negedge clk); #3 reset = 1'b1;
    #1;
    chk("mid_out_valid", {63'b0, out_valid}, 64'h0);
    chk("mid_imem_addr", {32'b0, imem_addr}, 64'h0);
    chk("mid_imem_read", {63'b0, imem_read}, 64'h0);
    cyc(1, 0, 0); reset = 1'b0;
    repeat (5) cyc(1, 0, 0);

    // Randomized traffic, including pc wrap via random targets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
      reset = ($urandom_range(0, 249) == 0);
    end
    cyc(1, 0, 0); reset = 1'b0;
    repeat (4) cyc(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
